qspi_line_prefetcher: RTL and testbench
=======================================

Name: qspi_line_prefetcher

Overview:
- Sits between the XIP cache-miss logic and the QSPI flash line reader.
- Forwards demand line fetches to the reader. After each demand line is served, it automatically fetches the next sequential line into a one-entry prefetch buffer.
- A later miss to that next line is served from the buffer without a flash transaction, which hides QSPI latency for straight-line code.

Parameters:
- LINE_SIZE, 128, line width in bits; must match the flash reader and cache line.
- AW, 24, flash byte-address width.
- PREFETCH_EN, 1, 1 enables next-line prefetch; 0 gives a pure pass-through (buffer never filled).

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- req  in  1  demand line request; sampled only when ready=1
- req_addr  in  AW  demand byte address; bits [3:0] ignored (line-aligned)
- ready  out  1  block can accept req this cycle
- resp_valid  out  1  one-cycle pulse; resp_line valid
- resp_line  out  LINE_SIZE  returned line
- flush  in  1  invalidate prefetch buffer
- fr_rd  out  1  one-cycle read strobe to flash reader
- fr_addr  out  AW  flash read address, {tag,4'h0}
- fr_done  in  1  one-cycle line-complete pulse from reader
- fr_line  in  LINE_SIZE  line data from reader, valid with fr_done

Behaviour:
- Internal state:
  - pb_valid, pb_tag[AW-5:0], pb_data: prefetch buffer.
  - pend_tag: latched demand tag.
  - pf_discard flag.
- Reset values:
  - Outputs: ready=1, resp_valid=0, resp_line=0, fr_rd=0, fr_addr=0.
  - Internal: pb_valid=0, pf_discard=0, state=IDLE.
  - Reset mid-transaction aborts everything; the reader shares HRESETn.
- Tag arithmetic: tag = addr[AW-1:4]. Next tag = tag+1 modulo 2^(AW-4), so 0xFFFFF wraps to 0x00000.
- States: IDLE, DEMAND, PF, PF_WAIT. ready=1 in IDLE and PF only; req with ready=0 is ignored.
- IDLE, req, buffer hit (pb_valid & pb_tag==tag & ~flush):
  - Next cycle: resp_valid=1, resp_line=pb_data. Hit latency is 1.
  - If PREFETCH_EN, the same cycle drives fr_rd=1 with fr_addr for tag+1, clears pb_valid, and moves to PF. Otherwise stays in IDLE.
- IDLE, req, miss: next cycle fr_rd=1, fr_addr={tag,4'h0}; go to DEMAND.
- DEMAND:
  - On fr_done: next cycle resp_valid=1, resp_line=fr_line (registered).
  - If PREFETCH_EN, the same cycle drives fr_rd=1 for tag+1 and moves to PF; otherwise goes to IDLE.
  - Miss latency is (reader time) + 2 cycles from req.
- PF, fr_done, no req:
  - If pf_discard=0: pb_data<=fr_line, pb_tag<=pf tag, pb_valid<=1.
  - Clear pf_discard; go to IDLE.
- PF, req: latch pend_tag, go to PF_WAIT. The in-flight flash read is never aborted.
- PF_WAIT, on fr_done:
  - Fill the buffer as above.
  - If pend_tag matches the prefetched tag and not discarded: behave as an IDLE hit (resp next cycle, prefetch pend_tag+1, go to PF).
  - Otherwise: fr_rd for pend_tag next cycle, go to DEMAND.
- req and fr_done in the same cycle in PF: go straight to the PF_WAIT resolution using that fr_done.
- flush:
  - Clears pb_valid immediately.
  - In PF/PF_WAIT, sets pf_discard so the in-flight line is dropped.
  - flush with req in IDLE: flush wins and the request is treated as a miss.
- fr_rd is never asserted while a reader transaction is outstanding. It is asserted at most once per transaction.

Decomposition:
- Shared package qspi_xip_pkg:
  - LINE_SIZE, AW, TAG_W=AW-4.
  - State enum (IDLE, DEMAND, PF, PF_WAIT).
  - tag_next() helper.
- Sub-module qspi_pf_buffer: single-entry tag/valid/data register with fill, invalidate and compare ports.
- The FSM stays in the top module.

Test Plan:
- Cold miss: req addr 0x001230, reader returns line L0 after 40 cycles.
  - Expect fr_rd with fr_addr=0x001230, then resp_valid with L0 one cycle after fr_done.
  - Expect fr_rd with fr_addr=0x001240 in the same cycle as resp_valid.
- Sequential hit: after the prefetch of 0x001240 completes, req 0x001248.
  - Expect resp_valid with the prefetched line 1 cycle later, with no demand fr_rd.
  - Expect a new fr_rd with fr_addr=0x001250.
- Request during prefetch:
  - Matching case: req 0x001240 while the prefetch of 0x001240 is in flight. Expect no extra fr_rd; resp one cycle after fr_done.
  - Non-matching case: req 0x008000. Expect fr_rd with fr_addr=0x008000 one cycle after the prefetch fr_done.
- Wrap-around: demand 0xFFFFF0. Expect the prefetch fr_addr to be 0x000000.
- Flush: assert flush while the prefetch of 0x001240 is in flight, then req 0x001240.
  - Expect the buffered line discarded and a demand fr_rd with fr_addr=0x001240.
- Reset mid-DEMAND: pulse HRESETn low while waiting for fr_done.
  - Expect resp_valid=0, ready=1, pb_valid=0.
  - Expect a subsequent req to start a fresh demand fetch.

Source files
------------

// File: rtl/qspi_xip_pkg.sv
// QSPI XIP shared constants and types.
// Line geometry, prefetcher states and tag arithmetic.
package qspi_xip_pkg;

  localparam int LINE_SIZE = 128;
  localparam int AW        = 24;
  localparam int TAG_W     = AW - 4;

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    IDLE,
    DEMAND,
    PF,
    PF_WAIT
  } pf_state_t;

  function automatic tag_t tag_next(input tag_t t);
    return t + tag_t'(1);
  endfunction

endpackage

// File: rtl/qspi_pf_buffer.sv
// Single-entry line buffer for the next-line prefetcher.
// Holds one tagged line; invalidate wins over fill.
module qspi_pf_buffer
  import qspi_xip_pkg::*;
#(
  parameter int LW = LINE_SIZE
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [LW-1:0]    fill_data,
  input  logic             inval,
  input  logic [TAG_W-1:0] cmp_tag,
  output logic             hit,
  output logic [LW-1:0]    data
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  // Entry register: invalidate first, then fill
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

  assign hit = valid && (tag == cmp_tag);

endmodule

// File: rtl/qspi_line_prefetcher.sv
// XIP next-line prefetcher in front of the QSPI line reader.
// Demand misses go to flash; the following line is prefetched.
module qspi_line_prefetcher #(
  parameter int LINE_SIZE   = qspi_xip_pkg::LINE_SIZE,
  parameter int AW          = qspi_xip_pkg::AW,
  parameter bit PREFETCH_EN = 1'b1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 req,
  input  logic [AW-1:0]        req_addr,
  output logic                 ready,
  output logic                 resp_valid,
  output logic [LINE_SIZE-1:0] resp_line,
  input  logic                 flush,
  output logic                 fr_rd,
  output logic [AW-1:0]        fr_addr,
  input  logic                 fr_done,
  input  logic [LINE_SIZE-1:0] fr_line
);

  import qspi_xip_pkg::*;

  pf_state_t            state, state_n;
  tag_t                 req_tag, rtag;
  tag_t                 pend_tag, pend_n;
  tag_t                 pf_tag, pf_n;
  logic                 discard, discard_n;
  logic                 discard_now, resolve;
  logic                 rv_n, rd_n;
  logic [LINE_SIZE-1:0] line_n;
  logic [AW-1:0]        addr_n;
  logic                 pb_fill, pb_inval, pb_hit;
  logic [LINE_SIZE-1:0] pb_data;
  logic                 unused_lo;

  assign req_tag     = req_addr[AW-1:4];
  assign unused_lo   = ^req_addr[3:0];
  assign ready       = (state == IDLE) || (state == PF);
  assign discard_now = discard | flush;

  qspi_pf_buffer #(
    .LW(LINE_SIZE)
  ) u_buf (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .fill      (pb_fill),
    .fill_tag  (pf_tag),
    .fill_data (fr_line),
    .inval     (pb_inval),
    .cmp_tag   (req_tag),
    .hit       (pb_hit),
    .data      (pb_data)
  );

  // Next state, next outputs and buffer control
  always_comb begin
    state_n   = state;
    pend_n    = pend_tag;
    pf_n      = pf_tag;
    discard_n = discard;
    rv_n      = 1'b0;
    line_n    = resp_line;
    rd_n      = 1'b0;
    addr_n    = fr_addr;
    pb_fill   = 1'b0;
    pb_inval  = flush;
    resolve   = 1'b0;
    rtag      = pend_tag;
    if (flush && (state == PF || state == PF_WAIT))
      discard_n = 1'b1;
    unique case (state)
      IDLE: begin
        if (req && pb_hit && !flush) begin
          rv_n   = 1'b1;
          line_n = pb_data;
          if (PREFETCH_EN) begin
            rd_n     = 1'b1;
            pf_n     = tag_next(req_tag);
            addr_n   = {tag_next(req_tag), 4'h0};
            pb_inval = 1'b1;
            state_n  = PF;
          end
        end else if (req) begin
          rd_n    = 1'b1;
          addr_n  = {req_tag, 4'h0};
          pend_n  = req_tag;
          state_n = DEMAND;
        end
      end
      DEMAND: begin
        if (fr_done) begin
          rv_n   = 1'b1;
          line_n = fr_line;
          if (PREFETCH_EN) begin
            rd_n    = 1'b1;
            pf_n    = tag_next(pend_tag);
            addr_n  = {tag_next(pend_tag), 4'h0};
            state_n = PF;
          end else begin
            state_n = IDLE;
          end
        end
      end
      PF: begin
        if (fr_done && req) begin
          resolve = 1'b1;
          rtag    = req_tag;
        end else if (fr_done) begin
          pb_fill   = !discard_now;
          discard_n = 1'b0;
          state_n   = IDLE;
        end else if (req) begin
          pend_n  = req_tag;
          state_n = PF_WAIT;
        end
      end
      PF_WAIT: begin
        if (fr_done)
          resolve = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (resolve) begin
      discard_n = 1'b0;
      if (!discard_now && rtag == pf_tag) begin
        rv_n     = 1'b1;
        line_n   = fr_line;
        rd_n     = 1'b1;
        pf_n     = tag_next(rtag);
        addr_n   = {tag_next(rtag), 4'h0};
        pb_inval = 1'b1;
        state_n  = PF;
      end else begin
        pb_fill = !discard_now;
        rd_n    = 1'b1;
        addr_n  = {rtag, 4'h0};
        pend_n  = rtag;
        state_n = DEMAND;
      end
    end
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_n;
  end

  // Registered outputs and transaction bookkeeping
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      resp_valid <= 1'b0;
      resp_line  <= '0;
      fr_rd      <= 1'b0;
      fr_addr    <= '0;
      pend_tag   <= '0;
      pf_tag     <= '0;
      discard    <= 1'b0;
    end else begin
      resp_valid <= rv_n;
      resp_line  <= line_n;
      fr_rd      <= rd_n;
      fr_addr    <= addr_n;
      pend_tag   <= pend_n;
      pf_tag     <= pf_n;
      discard    <= discard_n;
    end
  end

endmodule

// File: tb/tb_qspi_line_prefetcher.sv
// Self-checking bench for qspi_line_prefetcher.
// Behavioural flash reader plus table-driven request vectors.
module tb_qspi_line_prefetcher;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic [23:0]  req_addr = '0;
  logic         flush = 1'b0;
  logic         ready, resp_valid, fr_rd, fr_done;
  logic [127:0] resp_line, fr_line;
  logic [23:0]  fr_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_cfg = 10;

  logic        busy;
  int          cnt;
  logic [23:0] cur;

  qspi_line_prefetcher #(
    .LINE_SIZE  (128),
    .AW         (24),
    .PREFETCH_EN(1'b1)
  ) u_dut (
    .HCLK      (clk),
    .HRESETn   (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .ready     (ready),
    .resp_valid(resp_valid),
    .resp_line (resp_line),
    .flush     (flush),
    .fr_rd     (fr_rd),
    .fr_addr   (fr_addr),
    .fr_done   (fr_done),
    .fr_line   (fr_line)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] line_of(input logic [23:0] a);
    return {a, 8'hC3, a ^ 24'h5A5A5A, 8'h3C,
            ~a, 8'h96, a + 24'h111111, 8'h69};
  endfunction

  // Flash reader: fr_done lat_cfg cycles after it sees fr_rd
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      fr_done <= 1'b0;
      fr_line <= '0;
      cnt     <= 0;
      cur     <= '0;
    end else begin
      fr_done <= 1'b0;
      if (fr_rd) begin
        busy <= 1'b1;
        cnt  <= lat_cfg;
        cur  <= fr_addr;
      end else if (busy) begin
        if (cnt <= 1) begin
          fr_done <= 1'b1;
          fr_line <= line_of(cur);
          busy    <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Reader protocol: no new strobe while a read is outstanding
  always @(negedge clk) begin
    if (rst_n && fr_rd) begin
      checks++;
      if (busy) begin
        errors++;
        $display("FAIL fr_rd_overlap: fr_rd addr 0x%06h while busy=%0b, required busy=0",
                 fr_addr, busy);
      end
    end
  end

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_l(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input logic [23:0] a, input logic fl, output int qc);
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL ready_timeout: ready=%0b, required 1", ready);
    end
    req      = 1'b1;
    req_addr = a;
    flush    = fl;
    qc       = cyc;
    @(posedge clk);
    #1;
    req   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_resp(input int qc, output int lat,
                           output logic [127:0] line, output int nrd,
                           output logic [23:0] rd_addr, output int rd_cyc,
                           output int dn_cyc, output logic pf_rd,
                           output logic [23:0] pf_addr);
    int n = 0;
    bit got = 1'b0;
    lat = -1; line = '0; nrd = 0; rd_addr = '0;
    rd_cyc = -1; dn_cyc = -1; pf_rd = 1'b0; pf_addr = '0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (fr_done && dn_cyc < 0) dn_cyc = cyc;
      if (resp_valid) begin
        got     = 1'b1;
        lat     = cyc - qc;
        line    = resp_line;
        pf_rd   = fr_rd;
        pf_addr = fr_addr;
      end else if (fr_rd) begin
        if (nrd == 0) begin
          rd_addr = fr_addr;
          rd_cyc  = cyc;
        end
        nrd++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid=%0b after %0d cycles, required 1",
               resp_valid, n);
    end
  endtask

  typedef struct {
    logic [23:0] addr;
    int          gap;
    logic        fl;
    int          exp_lat;
    int          exp_rd;
    logic [23:0] exp_line;
    logic [23:0] exp_pf;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           qc, lat, nrd, rdc, dnc;
    logic [127:0] ln;
    logic [23:0]  rda, pfa;
    logic         pfr;

    // reader latency 10: miss=13, hit=1, in-flight match=12-gap,
    // in-flight mismatch or discard=24-gap
    tbl[0]  = '{24'h001230, 0,  1'b0, 13, 1, 24'h001230, 24'h001240};
    tbl[1]  = '{24'h001248, 15, 1'b0, 1,  0, 24'h001240, 24'h001250};
    tbl[2]  = '{24'h001250, 2,  1'b0, 10, 0, 24'h001250, 24'h001260};
    tbl[3]  = '{24'h001260, 11, 1'b0, 1,  0, 24'h001260, 24'h001270};
    tbl[4]  = '{24'h008000, 3,  1'b0, 21, 1, 24'h008000, 24'h008010};
    tbl[5]  = '{24'h008010, 20, 1'b0, 1,  0, 24'h008010, 24'h008020};
    tbl[6]  = '{24'hFFFFF0, 20, 1'b0, 13, 1, 24'hFFFFF0, 24'h000000};
    tbl[7]  = '{24'h000004, 20, 1'b0, 1,  0, 24'h000000, 24'h000010};
    tbl[8]  = '{24'h000010, 20, 1'b1, 13, 1, 24'h000010, 24'h000020};
    tbl[9]  = '{24'h000020, 20, 1'b0, 1,  0, 24'h000020, 24'h000030};
    tbl[10] = '{24'h000030, 4,  1'b1, 20, 1, 24'h000030, 24'h000040};
    tbl[11] = '{24'h000040, 20, 1'b0, 1,  0, 24'h000040, 24'h000050};

    lat_cfg = 40;
    do_reset();
    chk_i("rst_ready", int'(ready), 1);
    chk_i("rst_resp_valid", int'(resp_valid), 0);
    chk_l("rst_resp_line", resp_line, 128'h0);
    chk_i("rst_fr_rd", int'(fr_rd), 0);
    chk_i("rst_fr_addr", int'(fr_addr), 0);

    issue(24'h001230, 1'b0, qc);
    wait_resp(qc, lat, ln, nrd, rda, rdc, dnc, pfr, pfa);
    chk_i("cold_rd_cnt", nrd, 1);
    chk_i("cold_rd_addr", int'(rda), 32'h001230);
    chk_i("cold_rd_cyc", rdc - qc, 1);
    chk_l("cold_line", ln, line_of(24'h001230));
    chk_i("cold_done_to_resp", qc + lat - dnc, 1);
    chk_i("cold_pf_rd", int'(pfr), 1);
    chk_i("cold_pf_addr", int'(pfa), 32'h001240);

    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    issue(24'h001240, 1'b0, qc);
    wait_resp(qc, lat, ln, nrd, rda, rdc, dnc, pfr, pfa);
    chk_i("flush_rd_cnt", nrd, 1);
    chk_i("flush_rd_addr", int'(rda), 32'h001240);
    chk_i("flush_rd_after_done", rdc - dnc, 1);
    chk_l("flush_line", ln, line_of(24'h001240));
    chk_i("flush_pf_addr", int'(pfa), 32'h001250);

    repeat (60) @(posedge clk);
    #1;
    chk_i("pb_valid_filled", int'(u_dut.u_buf.valid), 1);
    issue(24'h005000, 1'b0, qc);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #2;
    chk_i("midrst_resp_valid", int'(resp_valid), 0);
    chk_i("midrst_ready", int'(ready), 1);
    chk_i("midrst_pb_valid", int'(u_dut.u_buf.valid), 0);
    chk_i("midrst_fr_rd", int'(fr_rd), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(24'h001250, 1'b0, qc);
    wait_resp(qc, lat, ln, nrd, rda, rdc, dnc, pfr, pfa);
    chk_i("postrst_rd_cnt", nrd, 1);
    chk_i("postrst_rd_addr", int'(rda), 32'h001250);
    chk_i("postrst_lat", lat, 43);
    chk_l("postrst_line", ln, line_of(24'h001250));

    lat_cfg = 10;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].gap > 0) begin
        repeat (tbl[i].gap) @(posedge clk);
        #1;
      end
      issue(tbl[i].addr, tbl[i].fl, qc);
      wait_resp(qc, lat, ln, nrd, rda, rdc, dnc, pfr, pfa);
      chk_i($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      chk_l($sformatf("vec%0d_line", i), ln, line_of(tbl[i].exp_line));
      chk_i($sformatf("vec%0d_rd_cnt", i), nrd, tbl[i].exp_rd);
      if (tbl[i].exp_rd > 0)
        chk_i($sformatf("vec%0d_rd_addr", i), int'(rda),
              int'(tbl[i].exp_line));
      chk_i($sformatf("vec%0d_pf_rd", i), int'(pfr), 1);
      chk_i($sformatf("vec%0d_pf_addr", i), int'(pfa),
            int'(tbl[i].exp_pf));
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
